uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one Uart8 transmitter among NUM_REQ byte sources.
- Each source offers one byte at a time with a valid/ready handshake.
- The block selects a winner, drives the Uart8 tx interface (txEn, txStart, in) and tracks txBusy/txDone until the frame completes.
- A watchdog recovers from a transmitter that never answers. The block sits between on-chip producers and the Uart8 instance, running on the Uart8 clock.

---
 rtl/uart_tx_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one Uart8 transmitter among
// NUM_REQ byte sources, with a watchdog for a transmitter that never answers.
// Optional packet lock is enabled by defining UART_TX_ARBITER_PACKET_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    input  logic [NUM_REQ-1:0]   reqLast,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 txEn,
    output logic                 txStart,
    output logic [7:0]           txByte,
    input  logic                 txBusy,
    input  logic                 txDone,
    output logic                 timeoutErr
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       last_grant, last_grant_nx;
    logic [IW-1:0]       win_idx, take_idx;
    logic [IW:0]         cand;
    logic                win_found, take;
    logic [NUM_REQ-1:0]  grant_nx, ready_nx;
    logic [7:0]          byte_nx;
    logic                start_nx, err_nx;
    logic [WW-1:0]       wd_cnt, wd_nx;
    logic [GW-1:0]       gap_cnt, gap_nx;
    logic                frame_done, expire;
    logic [7:0]          req_bytes [NUM_REQ];

`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
    logic lock, lock_nx;
    logic last_flag, last_flag_nx;
`else
    logic unused_last;
    assign unused_last = ^reqLast;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = reqData[8*g +: 8];
    end

    // Round-robin search: first valid requester above lastGrant, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!win_found && reqValid[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Next-state and next-output logic for the arbiter FSM and its counters.
    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        byte_nx       = txByte;
        start_nx      = 1'b0;
        ready_nx      = '0;
        err_nx        = 1'b0;
        last_grant_nx = last_grant;
        wd_nx         = wd_cnt;
        gap_nx        = gap_cnt;
        take          = 1'b0;
        take_idx      = win_idx;
        frame_done    = 1'b0;
        expire        = 1'b0;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
        lock_nx       = lock;
        last_flag_nx  = last_flag;
`endif

        case (state)
            IDLE: begin
                take     = win_found;
                take_idx = win_idx;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
                if (lock) begin
                    take     = reqValid[last_grant];
                    take_idx = last_grant;
                    if (take) begin
                        wd_nx = '0;
                    end else if (wd_cnt == WD_LAST) begin
                        lock_nx = 1'b0;
                        err_nx  = 1'b1;
                        wd_nx   = '0;
                    end else begin
                        wd_nx = wd_cnt + WW'(1);
                    end
                end
`endif
                if (take) begin
                    state_nx           = START;
                    grant_nx           = '0;
                    grant_nx[take_idx] = 1'b1;
                    byte_nx            = req_bytes[take_idx];
                    last_grant_nx      = take_idx;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
                    last_flag_nx       = reqLast[take_idx];
`endif
                end
            end
            START: begin
                start_nx = 1'b1;
                ready_nx = grant;
                wd_nx    = '0;
                state_nx = WAIT_BUSY;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
                lock_nx  = !last_flag;
`endif
            end
            WAIT_BUSY: begin
                if (txDone) begin
                    frame_done = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    expire = 1'b1;
                end else begin
                    wd_nx = wd_cnt + WW'(1);
                    if (txBusy) begin
                        state_nx = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (txDone) begin
                    frame_done = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    expire = 1'b1;
                end else begin
                    wd_nx = wd_cnt + WW'(1);
                end
            end
            GAP: begin
                if (gap_cnt <= GW'(1)) begin
                    gap_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (frame_done) begin
            grant_nx = '0;
            wd_nx    = '0;
            if (GAP_CYCLES == 0) begin
                state_nx = IDLE;
            end else begin
                state_nx = GAP;
                gap_nx   = GAP_LOAD;
            end
        end

        if (expire) begin
            grant_nx = '0;
            wd_nx    = '0;
            err_nx   = 1'b1;
            state_nx = IDLE;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
            lock_nx  = 1'b0;
`endif
        end
    end

    // State and registered outputs; reset gives requester 0 first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            reqReady   <= '0;
            txStart    <= 1'b0;
            timeoutErr <= 1'b0;
            txByte     <= 8'h00;
            last_grant <= IW'(NUM_REQ - 1);
            wd_cnt     <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            reqReady   <= ready_nx;
            txStart    <= start_nx;
            timeoutErr <= err_nx;
            txByte     <= byte_nx;
            last_grant <= last_grant_nx;
            wd_cnt     <= wd_nx;
            gap_cnt    <= gap_nx;
        end
    end

    // Transmitter enable comes up on the first edge out of reset and stays up.
    always_ff @(posedge clk) begin
        if (reset) begin
            txEn <= 1'b0;
        end else begin
            txEn <= 1'b1;
        end
    end

`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
    // Packet lock holds the transmitter for one requester until its last byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock      <= 1'b0;
            last_flag <= 1'b0;
        end else begin
            lock      <= lock_nx;
            last_flag <= last_flag_nx;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of uart_tx_arbiter against a simple
// Uart8 model. Instance A uses GAP_CYCLES=0, instance B uses GAP_CYCLES=3.
module tb_uart_tx_arbiter;

    localparam int FRAME = 20;

    logic        clk;
    logic        reset;

    logic [3:0]  validA, lastA, readyA, grantA;
    logic [31:0] dataA;
    logic        txEnA, txStartA, timeoutErrA;
    logic [7:0]  txByteA;
    logic        mBusyA, mDoneA, muteA;
    int          mCntA;

    logic [3:0]  validB, lastB, readyB, grantB;
    logic [31:0] dataB;
    logic        txEnB, txStartB, timeoutErrB;
    logic [7:0]  txByteB;
    logic        mBusyB, mDoneB;
    int          mCntB;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dutA (
        .clk(clk), .reset(reset),
        .reqValid(validA), .reqData(dataA), .reqLast(lastA), .reqReady(readyA),
        .grant(grantA), .txEn(txEnA), .txStart(txStartA), .txByte(txByteA),
        .txBusy(mBusyA), .txDone(mDoneA), .timeoutErr(timeoutErrA)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(100)) dutB (
        .clk(clk), .reset(reset),
        .reqValid(validB), .reqData(dataB), .reqLast(lastB), .reqReady(readyB),
        .grant(grantB), .txEn(txEnB), .txStart(txStartB), .txByte(txByteB),
        .txBusy(mBusyB), .txDone(mDoneB), .timeoutErr(timeoutErrB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uart8 model for A: busy one cycle after txStart, done FRAME cycles later unless muted.
    always @(posedge clk) begin
        if (reset) begin
            mBusyA <= 1'b0;
            mDoneA <= 1'b0;
            mCntA  <= 0;
        end else begin
            mDoneA <= 1'b0;
            if (txStartA) begin
                mBusyA <= 1'b1;
                mCntA  <= 1;
            end else if (mBusyA) begin
                if (mCntA == FRAME && !muteA) begin
                    mBusyA <= 1'b0;
                    mDoneA <= 1'b1;
                end else begin
                    mCntA <= mCntA + 1;
                end
            end
        end
    end

    // Uart8 model for B, same timing, never muted.
    always @(posedge clk) begin
        if (reset) begin
            mBusyB <= 1'b0;
            mDoneB <= 1'b0;
            mCntB  <= 0;
        end else begin
            mDoneB <= 1'b0;
            if (txStartB) begin
                mBusyB <= 1'b1;
                mCntB  <= 1;
            end else if (mBusyB) begin
                if (mCntB == FRAME) begin
                    mBusyB <= 1'b0;
                    mDoneB <= 1'b1;
                end else begin
                    mCntB <= mCntB + 1;
                end
            end
        end
    end

    // Hard stop in case the directed sequence wedges.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l);
        validA = v;
        dataA  = d;
        lastA  = l;
    endtask

    task automatic doReset();
        applyStimulus(4'b0, 32'h0, 4'b0);
        validB = 4'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        tick();
    endtask

    // Win edge then START edge: checks grant/byte, then txStart and reqReady.
    task automatic startFrame(input string tag, input logic [3:0] expGrant, input logic [7:0] expByte);
        tick();
        checkOutput({tag, "_grant"}, 32'(grantA), 32'(expGrant));
        checkOutput({tag, "_byte"}, 32'(txByteA), 32'(expByte));
        checkOutput({tag, "_start_early"}, 32'(txStartA), 32'd0);
        tick();
        checkOutput({tag, "_start"}, 32'(txStartA), 32'd1);
        checkOutput({tag, "_ready"}, 32'(readyA), 32'(expGrant));
    endtask

    // Wait for the model's txDone, then check the grant is released.
    task automatic finishFrame(input string tag, input logic [3:0] expGrant);
        logic [3:0] readySeen;
        int n;
        readySeen = 4'b0;
        n = 0;
        tick();
        checkOutput({tag, "_start_pulse"}, 32'(txStartA), 32'd0);
        readySeen = readySeen | readyA;
        while (!mDoneA && n < 200) begin
            tick();
            readySeen = readySeen | readyA;
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(mDoneA), 32'd1);
        checkOutput({tag, "_grant_hold"}, 32'(grantA), 32'(expGrant));
        checkOutput({tag, "_ready_once"}, 32'(readySeen), 32'd0);
        tick();
        checkOutput({tag, "_grant_clr"}, 32'(grantA), 32'd0);
        checkOutput({tag, "_start_idle"}, 32'(txStartA), 32'd0);
    endtask

    initial begin
        int w;
        int n;
        muteA  = 1'b0;
        validB = 4'b0;
        dataB  = 32'h0;
        lastB  = 4'b0;
        applyStimulus(4'b0, 32'h0, 4'b0);

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_grant", 32'(grantA), 32'd0);
        checkOutput("rst_ready", 32'(readyA), 32'd0);
        checkOutput("rst_start", 32'(txStartA), 32'd0);
        checkOutput("rst_err", 32'(timeoutErrA), 32'd0);
        checkOutput("rst_byte", 32'(txByteA), 32'h00);
        checkOutput("rst_txen", 32'(txEnA), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("txen_up", 32'(txEnA), 32'd1);

        // Single requester 0 sends D6
        applyStimulus(4'b0001, 32'h000000D6, 4'b0);
        startFrame("single", 4'b0001, 8'hD6);
        applyStimulus(4'b0000, 32'h000000D6, 4'b0);
        finishFrame("single", 4'b0001);
        checkOutput("single_byte_hold", 32'(txByteA), 32'hD6);

        // All four valid continuously: order 0,1,2,3,0
        doReset();
        applyStimulus(4'b1111, 32'h13121110, 4'b0);
        for (int i = 0; i < 5; i++) begin
            w = i % 4;
            startFrame("rr", 4'(4'b0001 << w), 8'(8'h10 + w));
            if (i == 4) applyStimulus(4'b0000, 32'h13121110, 4'b0);
            finishFrame("rr", 4'(4'b0001 << w));
        end

        // Watchdog: model never answers with txDone
        doReset();
        muteA = 1'b1;
        applyStimulus(4'b0001, 32'h0000A1A0, 4'b0);
        startFrame("wd", 4'b0001, 8'hA0);
        applyStimulus(4'b0000, 32'h0000A1A0, 4'b0);
        repeat (99) tick();
        checkOutput("wd_err_early", 32'(timeoutErrA), 32'd0);
        checkOutput("wd_grant_hold", 32'(grantA), 32'b0001);
        tick();
        checkOutput("wd_err", 32'(timeoutErrA), 32'd1);
        checkOutput("wd_grant_clr", 32'(grantA), 32'd0);
        muteA = 1'b0;
        applyStimulus(4'b0011, 32'h0000A1A0, 4'b0);
        startFrame("wd_next", 4'b0010, 8'hA1);
        checkOutput("wd_err_pulse", 32'(timeoutErrA), 32'd0);
        applyStimulus(4'b0000, 32'h0000A1A0, 4'b0);
        finishFrame("wd_next", 4'b0010);

        // Reset in WAIT_DONE while requester 2 owns the transmitter
        doReset();
        applyStimulus(4'b0100, 32'h00C20000, 4'b0);
        startFrame("mid", 4'b0100, 8'hC2);
        applyStimulus(4'b0000, 32'h00C20000, 4'b0);
        repeat (3) tick();
        checkOutput("mid_owner", 32'(grantA), 32'b0100);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_grant", 32'(grantA), 32'd0);
        checkOutput("mid_rst_start", 32'(txStartA), 32'd0);
        checkOutput("mid_rst_txen", 32'(txEnA), 32'd0);
        applyStimulus(4'b0101, 32'h00C200C0, 4'b0);
        reset = 1'b0;
        startFrame("mid_r0", 4'b0001, 8'hC0);
        checkOutput("mid_txen", 32'(txEnA), 32'd1);
        applyStimulus(4'b0100, 32'h00C200C0, 4'b0);
        finishFrame("mid_r0", 4'b0001);
        startFrame("mid_r2", 4'b0100, 8'hC2);
        applyStimulus(4'b0000, 32'h00C200C0, 4'b0);
        finishFrame("mid_r2", 4'b0100);

        // Three idle gap cycles on instance B
        doReset();
        validB = 4'b0011;
        dataB  = 32'h0000B1B0;
        tick();
        checkOutput("gap_grant0", 32'(grantB), 32'b0001);
        tick();
        checkOutput("gap_start0", 32'(txStartB), 32'd1);
        checkOutput("gap_ready0", 32'(readyB), 32'b0001);
        validB = 4'b0010;
        n = 0;
        while (!mDoneB && n < 200) begin
            tick();
            n++;
        end
        checkOutput("gap_done_seen", 32'(mDoneB), 32'd1);
        tick();
        checkOutput("gap_c1", 32'(grantB), 32'd0);
        tick();
        checkOutput("gap_c2", 32'(grantB), 32'd0);
        tick();
        checkOutput("gap_c3", 32'(grantB), 32'd0);
        tick();
        checkOutput("gap_idle", 32'(grantB), 32'd0);
        checkOutput("gap_idle_start", 32'(txStartB), 32'd0);
        tick();
        checkOutput("gap_grant1", 32'(grantB), 32'b0010);
        checkOutput("gap_byte1", 32'(txByteB), 32'hB1);
        tick();
        checkOutput("gap_start1", 32'(txStartB), 32'd1);
        validB = 4'b0000;
        n = 0;
        while (!mDoneB && n < 200) begin
            tick();
            n++;
        end
        checkOutput("gap_done1_seen", 32'(mDoneB), 32'd1);
        tick();

        // Requester 1 sends a 3-byte packet while requester 0 waits
        doReset();
        applyStimulus(4'b0010, 32'h0000A1C0, 4'b0000);
        startFrame("pkt_b0", 4'b0010, 8'hA1);
        applyStimulus(4'b0011, 32'h0000B2C0, 4'b0000);
        finishFrame("pkt_b0", 4'b0010);
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
        startFrame("pkt_b1", 4'b0010, 8'hB2);
        applyStimulus(4'b0011, 32'h0000C3C0, 4'b0010);
        finishFrame("pkt_b1", 4'b0010);
        startFrame("pkt_b2", 4'b0010, 8'hC3);
        applyStimulus(4'b0001, 32'h0000C3C0, 4'b0000);
        finishFrame("pkt_b2", 4'b0010);
        startFrame("pkt_r0", 4'b0001, 8'hC0);
        applyStimulus(4'b0000, 32'h0000C3C0, 4'b0000);
        finishFrame("pkt_r0", 4'b0001);
`else
        startFrame("pkt_r0", 4'b0001, 8'hC0);
        applyStimulus(4'b0010, 32'h0000B2C0, 4'b0000);
        finishFrame("pkt_r0", 4'b0001);
        startFrame("pkt_b1", 4'b0010, 8'hB2);
        applyStimulus(4'b0000, 32'h0000B2C0, 4'b0000);
        finishFrame("pkt_b1", 4'b0010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
